// File: rtl/mem_req_arbiter.sv
// Two-way round-robin arbiter merging the instruction and data SRAM-like ports
// onto one downstream port, tracking in-order responses with an owner-ID FIFO.
module mem_req_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  input  logic [3:0]  inst_sram_wstrb,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,

  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  input  logic [3:0]  data_sram_wstrb,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,

  output logic [3:0]  outstanding,
  output logic        resp_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [3:0] DEPTH_CNT = 4'(DEPTH);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [DEPTH-1:0]  fifo_q;
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [3:0]        outstanding_q, outstanding_d;
  logic              resp_err_q;
  logic              push, pop, head_id, grant;

  assign push    = (state_q == ISSUE) && mem_addr_ok;
  assign pop     = mem_data_ok && (outstanding_q != 4'd0);
  assign head_id = fifo_q[rptr_q];

  // Ties go to the side that did not win last time; a lone requester always wins.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    grant        = data_sram_req;
    if (inst_sram_req && data_sram_req) begin
      grant = ~last_grant_q;
    end
    case (state_q)
      IDLE: begin
        if ((inst_sram_req || data_sram_req) && (outstanding_q < DEPTH_CNT)) begin
          owner_d = grant;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_addr_ok) begin
          last_grant_d = owner_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    outstanding_d = outstanding_q;
    case ({push, pop})
      2'b10:   outstanding_d = outstanding_q + 4'd1;
      2'b01:   outstanding_d = outstanding_q - 4'd1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      outstanding_q <= 4'd0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      outstanding_q <= outstanding_d;
      resp_err_q    <= resp_err_q | (mem_data_ok && (outstanding_q == 4'd0));
    end
  end

  // Pointers wrap at DEPTH, which need not be a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fifo_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= owner_q;
        wptr_q         <= (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= (rptr_q == LAST_PTR) ? '0 : rptr_q + 1'b1;
      end
    end
  end

  assign mem_req   = (state_q == ISSUE);
  assign mem_wr    = owner_q ? data_sram_wr    : inst_sram_wr;
  assign mem_size  = owner_q ? data_sram_size  : inst_sram_size;
  assign mem_addr  = owner_q ? data_sram_addr  : inst_sram_addr;
  assign mem_wstrb = owner_q ? data_sram_wstrb : inst_sram_wstrb;
  assign mem_wdata = owner_q ? data_sram_wdata : inst_sram_wdata;

  assign inst_sram_addr_ok = push && !owner_q;
  assign data_sram_addr_ok = push &&  owner_q;
  assign inst_sram_data_ok = pop  && !head_id;
  assign data_sram_data_ok = pop  &&  head_id;
  assign inst_sram_rdata   = mem_rdata;
  assign data_sram_rdata   = mem_rdata;

  assign outstanding = outstanding_q;
  assign resp_err    = resp_err_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed-vector bench for mem_req_arbiter (DEPTH=4): grant order, response
// routing, back-pressure at full, spurious responses and mid-issue reset.
module tb_mem_req_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        instReq, instWr, dataReq, dataWr;
  logic [1:0]  instSize, dataSize;
  logic [31:0] instAddr, instWdata, dataAddr, dataWdata;
  logic [3:0]  instWstrb, dataWstrb;
  logic        instAddrOk, instDataOk, dataAddrOk, dataDataOk;
  logic [31:0] instRdata, dataRdata;
  logic        memReq, memWr, memAddrOk, memDataOk;
  logic [1:0]  memSize;
  logic [31:0] memAddr, memWdata, memRdata;
  logic [3:0]  memWstrb;
  logic [3:0]  outstanding;
  logic        respErr;

  int vectors = 0;
  int miscompares = 0;

  mem_req_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(instReq), .inst_sram_wr(instWr), .inst_sram_size(instSize),
    .inst_sram_addr(instAddr), .inst_sram_wdata(instWdata), .inst_sram_wstrb(instWstrb),
    .inst_sram_addr_ok(instAddrOk), .inst_sram_data_ok(instDataOk), .inst_sram_rdata(instRdata),
    .data_sram_req(dataReq), .data_sram_wr(dataWr), .data_sram_size(dataSize),
    .data_sram_addr(dataAddr), .data_sram_wdata(dataWdata), .data_sram_wstrb(dataWstrb),
    .data_sram_addr_ok(dataAddrOk), .data_sram_data_ok(dataDataOk), .data_sram_rdata(dataRdata),
    .mem_req(memReq), .mem_wr(memWr), .mem_size(memSize), .mem_addr(memAddr),
    .mem_wstrb(memWstrb), .mem_wdata(memWdata), .mem_addr_ok(memAddrOk),
    .mem_data_ok(memDataOk), .mem_rdata(memRdata),
    .outstanding(outstanding), .resp_err(respErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 ns after the rising edge; checks follow 1 ns later.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    instReq = 0; instWr = 0; instSize = 2'd2; instAddr = '0; instWdata = '0; instWstrb = '0;
    dataReq = 0; dataWr = 0; dataSize = 2'd2; dataAddr = '0; dataWdata = '0; dataWstrb = '0;
    memAddrOk = 0; memDataOk = 0; memRdata = '0;
    #2;
    checkOutput("rst_mem_req", memReq, 0);
    checkOutput("rst_outstanding", outstanding, 0);
    checkOutput("rst_resp_err", respErr, 0);
    checkOutput("rst_addr_ok", {instAddrOk, dataAddrOk}, 0);
    applyStimulus();
    resetn = 1'b1;

    // Single instruction read: 1-cycle latency, combinational addr_ok and data_ok.
    applyStimulus();
    instReq = 1; instAddr = 32'h1C00_0000;
    #1 checkOutput("t1_idle_mem_req", memReq, 0);
    applyStimulus();
    memAddrOk = 1;
    #1 checkOutput("t1_mem_req", memReq, 1);
    checkOutput("t1_mem_addr", memAddr, 32'h1C00_0000);
    checkOutput("t1_inst_addr_ok", instAddrOk, 1);
    checkOutput("t1_data_addr_ok", dataAddrOk, 0);
    applyStimulus();
    instReq = 0; memAddrOk = 0; memDataOk = 1; memRdata = 32'h1234_5678;
    #1 checkOutput("t1_outstanding_1", outstanding, 1);
    checkOutput("t1_inst_data_ok", instDataOk, 1);
    checkOutput("t1_data_data_ok", dataDataOk, 0);
    checkOutput("t1_inst_rdata", instRdata, 32'h1234_5678);
    checkOutput("t1_data_rdata", dataRdata, 32'h1234_5678);
    applyStimulus();
    memDataOk = 0;
    #1 checkOutput("t1_outstanding_0", outstanding, 0);

    // Fresh reset, then both requesting: grants alternate inst, data, inst, data.
    resetn = 0;
    applyStimulus();
    resetn = 1;
    instReq = 1; instAddr = 32'h0000_00A0; dataReq = 1; dataAddr = 32'h0000_00B0; memAddrOk = 1;
    #1 checkOutput("t2_c0_mem_req", memReq, 0);
    for (int k = 1; k < 8; k++) begin
      applyStimulus();
      #1;
      if (k % 2 == 1) begin
        checkOutput($sformatf("t2_c%0d_mem_req", k), memReq, 1);
        checkOutput($sformatf("t2_c%0d_addr", k), memAddr, (k == 1 || k == 5) ? 32'hA0 : 32'hB0);
        checkOutput($sformatf("t2_c%0d_inst_aok", k), instAddrOk, (k == 1 || k == 5) ? 1 : 0);
        checkOutput($sformatf("t2_c%0d_data_aok", k), dataAddrOk, (k == 3 || k == 7) ? 1 : 0);
      end else begin
        checkOutput($sformatf("t2_c%0d_mem_req", k), memReq, 0);
      end
    end
    applyStimulus();
    instReq = 0; dataReq = 0; memAddrOk = 0;
    #1 checkOutput("t2_outstanding_4", outstanding, 4);
    for (int k = 0; k < 4; k++) begin
      memDataOk = 1; memRdata = 32'h100 + k;
      #1 checkOutput($sformatf("t2_r%0d_inst_dok", k), instDataOk, (k % 2 == 0) ? 1 : 0);
      checkOutput($sformatf("t2_r%0d_data_dok", k), dataDataOk, (k % 2 == 1) ? 1 : 0);
      applyStimulus();
    end
    memDataOk = 0;
    #1 checkOutput("t2_outstanding_0", outstanding, 0);

    // Data-only requests with no responses: fill to 4, fifth waits for a pop.
    dataReq = 1; dataAddr = 32'h0000_0200; memAddrOk = 1;
    for (int k = 1; k < 8; k++) applyStimulus();
    applyStimulus();
    #1 checkOutput("t3_c8_outstanding", outstanding, 4);
    checkOutput("t3_c8_mem_req", memReq, 0);
    applyStimulus();
    #1 checkOutput("t3_c9_mem_req", memReq, 0);
    applyStimulus();
    memDataOk = 1;
    #1 checkOutput("t3_c10_mem_req", memReq, 0);
    checkOutput("t3_c10_data_dok", dataDataOk, 1);
    applyStimulus();
    memDataOk = 0;
    #1 checkOutput("t3_c11_outstanding", outstanding, 3);
    checkOutput("t3_c11_mem_req", memReq, 0);
    applyStimulus();
    #1 checkOutput("t3_c12_mem_req", memReq, 1);
    checkOutput("t3_c12_data_aok", dataAddrOk, 1);
    applyStimulus();
    dataReq = 0; memAddrOk = 0;
    #1 checkOutput("t3_c13_outstanding", outstanding, 4);
    memDataOk = 1;
    for (int k = 0; k < 4; k++) applyStimulus();
    memDataOk = 0;
    #1 checkOutput("t3_drained", outstanding, 0);
    checkOutput("t3_resp_err", respErr, 0);

    // Response with nothing pending: no routing, sticky error.
    memDataOk = 1;
    #1 checkOutput("t4_inst_dok", instDataOk, 0);
    checkOutput("t4_data_dok", dataDataOk, 0);
    applyStimulus();
    memDataOk = 0;
    #1 checkOutput("t4_resp_err", respErr, 1);
    checkOutput("t4_outstanding", outstanding, 0);
    instReq = 1; instAddr = 32'h0000_0100; memAddrOk = 1;
    applyStimulus();
    #1 checkOutput("t4_inst_aok", instAddrOk, 1);
    applyStimulus();
    instReq = 0; memAddrOk = 0;
    #1 checkOutput("t4_outstanding_1", outstanding, 1);
    checkOutput("t4_resp_err_held", respErr, 1);

    // Store stalled in ISSUE for 3 cycles, then reset mid-wait.
    dataReq = 1; dataWr = 1; dataWstrb = 4'hF; dataAddr = 32'h0000_00C0; dataWdata = 32'hDEAD_BEEF;
    for (int k = 1; k <= 3; k++) begin
      applyStimulus();
      #1 checkOutput($sformatf("t5_c%0d_mem_req", k), memReq, 1);
      checkOutput($sformatf("t5_c%0d_mem_wr", k), memWr, 1);
      checkOutput($sformatf("t5_c%0d_wstrb", k), memWstrb, 4'hF);
      checkOutput($sformatf("t5_c%0d_addr", k), memAddr, 32'hC0);
      checkOutput($sformatf("t5_c%0d_wdata", k), memWdata, 32'hDEAD_BEEF);
      checkOutput($sformatf("t5_c%0d_data_aok", k), dataAddrOk, 0);
    end
    memAddrOk = 1; resetn = 0;
    #1 checkOutput("t5_rst_mem_req", memReq, 0);
    checkOutput("t5_rst_data_aok", dataAddrOk, 0);
    checkOutput("t5_rst_outstanding", outstanding, 0);
    checkOutput("t5_rst_resp_err", respErr, 0);
    dataReq = 0; dataWr = 0; memAddrOk = 0;
    applyStimulus();
    resetn = 1; memDataOk = 1;
    #1 checkOutput("t5_late_dok", {instDataOk, dataDataOk}, 0);
    applyStimulus();
    memDataOk = 0;
    #1 checkOutput("t5_late_resp_err", respErr, 1);

    // After reset the first tie goes to the instruction side.
    instReq = 1; instAddr = 32'h0000_0300; dataReq = 1; dataAddr = 32'h0000_0400; memAddrOk = 1;
    applyStimulus();
    #1 checkOutput("t6_tie_addr", memAddr, 32'h300);
    checkOutput("t6_tie_inst_aok", instAddrOk, 1);
    instReq = 0; dataReq = 0; memAddrOk = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
